pc_sequencer: RTL and testbench

- Multi-cycle control FSM for the fetch/PC-update datapath: PC register, 3-bit PC source mux, PC+2 adder, return stack, and the 1-cycle-latency instruction block memory.
- Each instruction is fetched, latched, waits for execute completion, then the FSM selects the next-PC source and issues the return-stack push/pop.
- Tracks return-stack depth, faults on overflow/underflow, and provides halt.

---
 rtl/pc_sequencer.sv | 125 ++++++++++++
 tb/tb_pc_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch/latch/exec control FSM with return-stack depth tracking
module pc_sequencer #(
    parameter int RS_DEPTH = 16,
    parameter int DEPTH_W  = 5
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               Stall,
    input  logic [2:0]         inst_class,
    input  logic               branch_taken,
    input  logic               exec_done,
    output logic               PCWrite,
    output logic [2:0]         PCControl,
    output logic [1:0]         RStackOP,
    output logic               IRWrite,
    output logic [DEPTH_W-1:0] rs_depth,
    output logic               halted,
    output logic               fault
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_LATCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [2:0] CLS_JUMP   = 3'd1;
    localparam logic [2:0] CLS_BRANCH = 3'd2;
    localparam logic [2:0] CLS_CALL   = 3'd3;
    localparam logic [2:0] CLS_RET    = 3'd4;
    localparam logic [2:0] CLS_HALT   = 3'd5;

    localparam logic [2:0] SEL_STACK  = 3'd0;
    localparam logic [2:0] SEL_JUMP   = 3'd1;
    localparam logic [2:0] SEL_BRANCH = 3'd2;
    localparam logic [2:0] SEL_INC    = 3'd4;

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(RS_DEPTH);

    state_t state, state_nxt;
    logic   push, pop, stack_err;

    always_comb begin
        state_nxt = state;
        PCWrite   = 1'b0;
        IRWrite   = 1'b0;
        PCControl = SEL_INC;
        RStackOP  = 2'b00;
        push      = 1'b0;
        pop       = 1'b0;
        stack_err = 1'b0;
        if (!Stall) begin
            case (state)
                S_FETCH: state_nxt = S_LATCH;
                S_LATCH: begin
                    IRWrite   = 1'b1;
                    state_nxt = S_EXEC;
                end
                S_EXEC: begin
                    if (exec_done) begin
                        state_nxt = S_FETCH;
                        case (inst_class)
                            CLS_JUMP: begin
                                PCWrite   = 1'b1;
                                PCControl = SEL_JUMP;
                            end
                            CLS_BRANCH: begin
                                PCWrite   = 1'b1;
                                PCControl = branch_taken ? SEL_BRANCH : SEL_INC;
                            end
                            CLS_CALL: begin
                                if (rs_depth < DEPTH_MAX) begin
                                    PCWrite   = 1'b1;
                                    PCControl = SEL_JUMP;
                                    RStackOP  = 2'b01;
                                    push      = 1'b1;
                                end else begin
                                    stack_err = 1'b1;
                                    state_nxt = S_HALT;
                                end
                            end
                            CLS_RET: begin
                                if (rs_depth != '0) begin
                                    PCWrite   = 1'b1;
                                    PCControl = SEL_STACK;
                                    RStackOP  = 2'b10;
                                    pop       = 1'b1;
                                end else begin
                                    stack_err = 1'b1;
                                    state_nxt = S_HALT;
                                end
                            end
                            CLS_HALT: state_nxt = S_HALT;
                            default:  PCWrite   = 1'b1;
                        endcase
                    end
                end
                S_HALT:  state_nxt = S_HALT;
                default: state_nxt = S_FETCH;
            endcase
        end
    end

    // halted tracks entry into HALT on the same edge, so it is high for every HALT cycle
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state    <= S_FETCH;
            rs_depth <= '0;
            halted   <= 1'b0;
            fault    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (push)
                rs_depth <= rs_depth + DEPTH_W'(1);
            else if (pop)
                rs_depth <= rs_depth - DEPTH_W'(1);
            if (stack_err)
                fault <= 1'b1;
            if (state_nxt == S_HALT)
                halted <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed bench for pc_sequencer with a PC/return-stack datapath model
module tb_pc_sequencer;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        Stall = 1'b0;
    logic [2:0]  inst_class = 3'd0;
    logic        branch_taken = 1'b0;
    logic        exec_done = 1'b1;
    logic        PCWrite;
    logic [2:0]  PCControl;
    logic [1:0]  RStackOP;
    logic        IRWrite;
    logic [4:0]  rs_depth;
    logic        halted;
    logic        fault;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [15:0] JUMP_TGT   = 16'h0040;
    localparam logic [15:0] BRANCH_TGT = 16'h0010;

    pc_sequencer #(.RS_DEPTH(16), .DEPTH_W(5)) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .Stall        (Stall),
        .inst_class   (inst_class),
        .branch_taken (branch_taken),
        .exec_done    (exec_done),
        .PCWrite      (PCWrite),
        .PCControl    (PCControl),
        .RStackOP     (RStackOP),
        .IRWrite      (IRWrite),
        .rs_depth     (rs_depth),
        .halted       (halted),
        .fault        (fault)
    );

    always #5 CLK = ~CLK;

    // Datapath driven purely by the sequencer's strobes
    logic [15:0] pc;
    logic [15:0] stk [0:31];
    int          sp;

    always @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            pc <= 16'h0000;
            sp <= 0;
        end else begin
            if (PCWrite) begin
                case (PCControl)
                    3'd0:    pc <= stk[sp-1];
                    3'd1:    pc <= JUMP_TGT;
                    3'd2:    pc <= BRANCH_TGT;
                    default: pc <= pc + 16'd2;
                endcase
            end
            if (RStackOP == 2'b01) begin
                stk[sp] <= pc + 16'd2;
                sp      <= sp + 1;
            end else if (RStackOP == 2'b10) begin
                sp <= sp - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #2;
    endtask

    task automatic do_reset;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    // Entered with the FSM in FETCH; leaves it one cycle after EXEC
    task automatic instr(input string tag, input logic [2:0] cls, input logic taken,
                         input logic exp_pcw, input logic [2:0] exp_ctl, input logic [1:0] exp_op);
        inst_class   = cls;
        branch_taken = taken;
        exec_done    = 1'b1;
        #1;
        chk({tag, "_fetch_pcw"}, 32'(PCWrite), 32'd0);
        chk({tag, "_fetch_ir"},  32'(IRWrite), 32'd0);
        tick();
        chk({tag, "_latch_ir"},  32'(IRWrite), 32'd1);
        chk({tag, "_latch_pcw"}, 32'(PCWrite), 32'd0);
        tick();
        chk({tag, "_exec_pcw"},  32'(PCWrite),   32'(exp_pcw));
        chk({tag, "_exec_ctl"},  32'(PCControl), 32'(exp_ctl));
        chk({tag, "_exec_op"},   32'(RStackOP),  32'(exp_op));
        chk({tag, "_exec_ir"},   32'(IRWrite),   32'd0);
        tick();
    endtask

    initial begin
        tick();
        chk("rst_pcw",   32'(PCWrite),   32'd0);
        chk("rst_ir",    32'(IRWrite),   32'd0);
        chk("rst_ctl",   32'(PCControl), 32'd4);
        chk("rst_op",    32'(RStackOP),  32'd0);
        chk("rst_depth", 32'(rs_depth),  32'd0);
        chk("rst_halt",  32'(halted),    32'd0);
        chk("rst_fault", 32'(fault),     32'd0);
        Reset = 1'b0;

        // Sequential flow, then both branch outcomes into PC 0x0010
        for (int i = 0; i < 3; i++) instr("seq", 3'd0, 1'b0, 1'b1, 3'd4, 2'b00);
        chk("seq_pc", 32'(pc), 32'h6);
        instr("br_nt", 3'd2, 1'b0, 1'b1, 3'd4, 2'b00);
        chk("br_nt_pc", 32'(pc), 32'h8);
        instr("br_t", 3'd2, 1'b1, 1'b1, 3'd2, 2'b00);
        chk("br_t_pc", 32'(pc), 32'h10);
        instr("jump", 3'd1, 1'b0, 1'b1, 3'd1, 2'b00);
        chk("jump_pc", 32'(pc), 32'h40);
        instr("br_back", 3'd2, 1'b1, 1'b1, 3'd2, 2'b00);

        // CALL from 0x0010, RET back to 0x0012
        instr("call", 3'd3, 1'b0, 1'b1, 3'd1, 2'b01);
        chk("call_depth", 32'(rs_depth), 32'd1);
        chk("call_pc",    32'(pc),       32'h40);
        instr("ret", 3'd4, 1'b0, 1'b1, 3'd0, 2'b10);
        chk("ret_depth", 32'(rs_depth), 32'd0);
        chk("ret_pc",    32'(pc),       32'h12);
        instr("cls7", 3'd7, 1'b0, 1'b1, 3'd4, 2'b00);
        chk("cls7_pc", 32'(pc), 32'h14);

        // Stall held 4 cycles in EXEC
        inst_class = 3'd0;
        exec_done  = 1'b1;
        tick();
        tick();
        Stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("stall_pcw", 32'(PCWrite),  32'd0);
            chk("stall_op",  32'(RStackOP), 32'd0);
            chk("stall_ir",  32'(IRWrite),  32'd0);
            tick();
        end
        Stall = 1'b0;
        #1;
        chk("unstall_pcw", 32'(PCWrite),   32'd1);
        chk("unstall_ctl", 32'(PCControl), 32'd4);
        tick();
        chk("unstall_fetch_pcw", 32'(PCWrite), 32'd0);
        chk("unstall_pc",        32'(pc),      32'h16);
        tick();
        chk("unstall_latch_ir", 32'(IRWrite), 32'd1);
        tick();
        tick();

        // Async reset mid-EXEC at depth 3
        for (int i = 0; i < 3; i++) instr("call3", 3'd3, 1'b0, 1'b1, 3'd1, 2'b01);
        chk("depth3", 32'(rs_depth), 32'd3);
        inst_class = 3'd3;
        exec_done  = 1'b0;
        tick();
        tick();
        #1;
        chk("exec_wait_pcw", 32'(PCWrite), 32'd0);
        exec_done = 1'b1;
        Reset     = 1'b1;
        #1;
        chk("arst_depth", 32'(rs_depth),  32'd0);
        chk("arst_pcw",   32'(PCWrite),   32'd0);
        chk("arst_op",    32'(RStackOP),  32'd0);
        chk("arst_ctl",   32'(PCControl), 32'd4);
        tick();
        Reset = 1'b0;
        instr("post_rst", 3'd0, 1'b0, 1'b1, 3'd4, 2'b00);
        chk("post_rst_pc", 32'(pc), 32'h2);

        // Overflow on the 17th CALL
        do_reset();
        for (int i = 0; i < 16; i++) instr("call16", 3'd3, 1'b0, 1'b1, 3'd1, 2'b01);
        chk("depth16", 32'(rs_depth), 32'd16);
        instr("ovf", 3'd3, 1'b0, 1'b0, 3'd4, 2'b00);
        chk("ovf_fault", 32'(fault),    32'd1);
        chk("ovf_halt",  32'(halted),   32'd1);
        chk("ovf_depth", 32'(rs_depth), 32'd16);
        for (int i = 0; i < 3; i++) begin
            chk("ovf_pcw", 32'(PCWrite), 32'd0);
            chk("ovf_ir",  32'(IRWrite), 32'd0);
            tick();
        end

        // Underflow on RET at depth 0
        do_reset();
        instr("unf", 3'd4, 1'b0, 1'b0, 3'd4, 2'b00);
        chk("unf_fault", 32'(fault),    32'd1);
        chk("unf_halt",  32'(halted),   32'd1);
        chk("unf_depth", 32'(rs_depth), 32'd0);

        // HALT instruction is sticky until reset
        do_reset();
        instr("halt", 3'd5, 1'b0, 1'b0, 3'd4, 2'b00);
        chk("halt_flag",  32'(halted), 32'd1);
        chk("halt_fault", 32'(fault),  32'd0);
        for (int i = 0; i < 3; i++) tick();
        chk("halt_stays", 32'(halted),  32'd1);
        chk("halt_pcw",   32'(PCWrite), 32'd0);
        chk("halt_ir",    32'(IRWrite), 32'd0);
        Reset = 1'b1;
        #1;
        chk("halt_rst", 32'(halted), 32'd0);
        tick();
        Reset = 1'b0;
        instr("after_halt", 3'd0, 1'b0, 1'b1, 3'd4, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
